// File: rtl/class_argmax.sv
// ---------------------------------------------------------------------------
// class_argmax
//
// Purpose: running arg-max over one FP16 similarity score per class. The
// scores arrive in class order 0..NUM_CLASSES-1 from the FP16 dot-product
// adder tree. When the last class has been seen, the block reports the
// winning class index and its score with a one-cycle done pulse.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active low
//   start        in   begin a new query (clears running state, any state)
//   score_valid  in   score carries the next class score
//   score        in   FP16 score for the current class
//   busy         out  high while collecting scores
//   done         out  one-cycle pulse, result outputs valid
//   best_class   out  index of the winning class
//   best_score   out  FP16 score of the winner
//   nan_seen     out  sticky per query: a NaN score was received
//   overrun      out  sticky per query: score_valid arrived outside COLLECT
// ---------------------------------------------------------------------------
module class_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int WIDTH       = 16,  // only FP16 is supported
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             score_valid,
  input  logic [WIDTH-1:0] score,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] best_class,
  output logic [WIDTH-1:0] best_score,
  output logic             nan_seen,
  output logic             overrun
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_REPORT  = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic [15:0]      NEG_INF  = 16'hFC00;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_count;
  logic [IDX_W-1:0] r_best_class;
  logic [15:0]      r_best_score;
  logic             r_nan_seen;
  logic             r_overrun;

  logic             w_is_nan;
  logic             w_both_zero;
  logic             w_greater;

  // Maps FP16 onto an unsigned key with the same ordering: negative values
  // are bit-inverted (larger magnitude -> smaller key), positive values get
  // the sign bit flipped so they sit above every negative.
  function automatic logic [15:0] sort_key(input logic [15:0] x);
    return x[15] ? ~x : (x ^ 16'h8000);
  endfunction

  assign w_is_nan    = (score[14:10] == 5'h1F) && (score[9:0] != 10'd0);
  // +0 and -0 have different keys but must compare equal.
  assign w_both_zero = (score[14:0] == 15'd0) && (r_best_score[14:0] == 15'd0);
  assign w_greater   = !w_both_zero && (sort_key(score) > sort_key(r_best_score));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_best_class <= '0;
      r_best_score <= '0;
      r_nan_seen   <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (start) begin
      // start wins over everything; a score in the same cycle is dropped.
      r_state      <= S_COLLECT;
      r_count      <= '0;
      r_best_class <= '0;
      r_best_score <= NEG_INF;
      r_nan_seen   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (score_valid) r_overrun <= 1'b1;
        end
        S_COLLECT: begin
          if (score_valid) begin
            if (w_is_nan) begin
              r_nan_seen <= 1'b1;
            end else if (w_greater) begin
              r_best_class <= r_count;
              r_best_score <= score;
            end
            // Counter stops at the last class; it is cleared by the next start.
            if (r_count == LAST_IDX) begin
              r_state <= S_REPORT;
            end else begin
              r_count <= r_count + IDX_W'(1);
            end
          end
        end
        S_REPORT: begin
          if (score_valid) r_overrun <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state == S_COLLECT);
  assign done       = (r_state == S_REPORT);
  assign best_class = r_best_class;
  assign best_score = r_best_score;
  assign nan_seen   = r_nan_seen;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_class_argmax.sv
// ---------------------------------------------------------------------------
// tb_class_argmax
//
// Self-checking bench for class_argmax with NUM_CLASSES=4. Each query pushes
// its expected result (from a real-valued FP16 reference model) onto a
// scoreboard queue; a monitor pops and compares on every done pulse.
// Scenario tasks add inline checks of the literal expected results,
// latency, pulse width, overrun and reset behaviour.
// ---------------------------------------------------------------------------
module tb_class_argmax;

  localparam int NC = 4;
  localparam int IW = 2;

  typedef logic [15:0] arr4_t [NC];
  typedef struct {
    logic [IW-1:0] cls;
    logic [15:0]   score;
    logic          nan;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          score_valid = 1'b0;
  logic [15:0]   score = '0;
  logic          busy;
  logic          done;
  logic [IW-1:0] best_class;
  logic [15:0]   best_score;
  logic          nan_seen;
  logic          overrun;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_count = 0;
  exp_t sb_q[$];

  class_argmax #(.NUM_CLASSES(NC), .WIDTH(16), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .score_valid(score_valid),
    .score(score), .busy(busy), .done(done), .best_class(best_class),
    .best_score(best_score), .nan_seen(nan_seen), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference: decode FP16 to a real; infinities become +/-1e10, which lies
  // beyond the largest finite FP16 (65504).
  function automatic real fp16_to_real(input logic [15:0] x);
    int  e;
    real v;
    e = int'(x[14:10]);
    if (e == 0)       v = real'(x[9:0]) * (2.0 ** -24);
    else if (e == 31) v = 1.0e10;
    else              v = real'(1024 + int'(x[9:0])) * (2.0 ** (e - 25));
    return x[15] ? -v : v;
  endfunction

  function automatic exp_t model(input arr4_t s);
    exp_t r;
    real  best_v;
    real  v;
    r.cls = '0; r.score = 16'hFC00; r.nan = 1'b0;
    best_v = -1.0e10;
    for (int i = 0; i < NC; i++) begin
      if (s[i][14:10] == 5'h1F && s[i][9:0] != 10'd0) begin
        r.nan = 1'b1;
      end else begin
        v = fp16_to_real(s[i]);
        if (v > best_v) begin
          best_v = v; r.cls = IW'(i); r.score = s[i];
        end
      end
    end
    return r;
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst && done) begin
      exp_t e;
      done_count++;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done: done seen with no query pending (class=%0d score=%h)",
                 best_class, best_score);
      end else begin
        e = sb_q.pop_front();
        if (best_class !== e.cls || best_score !== e.score ||
            nan_seen !== e.nan || overrun !== 1'b0) begin
          n_fail++;
          $display("FAIL sb_result: got class=%0d score=%h nan=%b ovr=%b, want class=%0d score=%h nan=%b ovr=0",
                   best_class, best_score, nan_seen, overrun, e.cls, e.score, e.nan);
        end else begin
          $display("query done: class=%0d score=%h nan=%b", best_class, best_score, nan_seen);
        end
      end
    end
  end

  // Drives start plus four scores with 'gap' idle cycles between scores,
  // checks done latency and pulse width.
  task automatic drive_query(input arr4_t s, input int gap);
    sb_q.push_back(model(s));
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (i > 0) repeat (gap) begin @(posedge clk); #1; end
      score_valid = 1'b1; score = s[i];
      @(posedge clk); #1; score_valid = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_latency: done=%b one cycle after last sample, want 1", done);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b busy=%b on following cycle, want 0 0", done, busy);
    end
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({busy, done, best_class, best_score, nan_seen, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b class=%0d score=%h nan=%b ovr=%b, want all 0",
               busy, done, best_class, best_score, nan_seen, overrun);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b after release, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    drive_query('{16'h3C00, 16'h4000, 16'h3800, 16'hBC00}, 0);
    n_checks++;
    if (best_class !== 2'd1 || best_score !== 16'h4000 || nan_seen !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL basic: class=%0d score=%h nan=%b ovr=%b, want 1 4000 0 0",
               best_class, best_score, nan_seen, overrun);
    end
  endtask

  task automatic test_ties_zeros;
    drive_query('{16'h4000, 16'h4000, 16'h3C00, 16'h4000}, 0);
    n_checks++;
    if (best_class !== 2'd0 || best_score !== 16'h4000) begin
      n_fail++;
      $display("FAIL ties: class=%0d score=%h, want 0 4000", best_class, best_score);
    end
    drive_query('{16'h8000, 16'h0000, 16'hBC00, 16'hC000}, 0);
    n_checks++;
    if (best_class !== 2'd0 || best_score !== 16'h8000) begin
      n_fail++;
      $display("FAIL zeros: class=%0d score=%h, want 0 8000", best_class, best_score);
    end
  endtask

  task automatic test_nan;
    drive_query('{16'h7E00, 16'hBC00, 16'h7E00, 16'hC000}, 0);
    n_checks++;
    if (best_class !== 2'd1 || best_score !== 16'hBC00 || nan_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL nan_mixed: class=%0d score=%h nan=%b, want 1 bc00 1", best_class, best_score, nan_seen);
    end
    drive_query('{16'h7E00, 16'h7E00, 16'h7E00, 16'h7E00}, 0);
    n_checks++;
    if (best_class !== 2'd0 || best_score !== 16'hFC00 || nan_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL nan_all: class=%0d score=%h nan=%b, want 0 fc00 1", best_class, best_score, nan_seen);
    end
  endtask

  task automatic test_inf;
    drive_query('{16'h7BFF, 16'h7C00, 16'hFC00, 16'h0001}, 0);
    n_checks++;
    if (best_class !== 2'd1 || best_score !== 16'h7C00) begin
      n_fail++;
      $display("FAIL inf: class=%0d score=%h, want 1 7c00", best_class, best_score);
    end
    drive_query('{16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00}, 0);
    n_checks++;
    if (best_class !== 2'd0 || best_score !== 16'hFC00 || nan_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL neg_inf_all: class=%0d score=%h nan=%b, want 0 fc00 0", best_class, best_score, nan_seen);
    end
  endtask

  task automatic test_restart_overrun;
    int dc0;
    dc0 = done_count;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      score_valid = 1'b1; score = 16'h7000;
      @(posedge clk); #1;
    end
    score_valid = 1'b0;
    drive_query('{16'h3800, 16'h3C00, 16'h3800, 16'h3800}, 0);
    n_checks++;
    if (done_count - dc0 !== 1 || best_class !== 2'd1 || best_score !== 16'h3C00) begin
      n_fail++;
      $display("FAIL restart: dones=%0d class=%0d score=%h, want 1 1 3c00",
               done_count - dc0, best_class, best_score);
    end
    // Fifth score after done: flagged, never folded in.
    @(posedge clk); #1; score_valid = 1'b1; score = 16'h7C00;
    @(posedge clk); #1; score_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (overrun !== 1'b1 || best_class !== 2'd1 || best_score !== 16'h3C00 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun: ovr=%b class=%0d score=%h done=%b, want 1 1 3c00 0",
               overrun, best_class, best_score, done);
    end
  endtask

  task automatic test_reset_mid_and_gaps;
    int            dc0;
    logic [IW-1:0] c0;
    logic [15:0]   s0;
    dc0 = done_count;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      score_valid = 1'b1; score = 16'h4400;
      @(posedge clk); #1;
    end
    score_valid = 1'b0;
    rst = 1'b0;
    #2;  // no clock edge in between: reset must act asynchronously
    n_checks++;
    if ({busy, done, best_class, best_score, nan_seen, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: busy=%b done=%b class=%0d score=%h nan=%b ovr=%b, want all 0",
               busy, done, best_class, best_score, nan_seen, overrun);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    n_checks++;
    if (done_count !== dc0) begin
      n_fail++;
      $display("FAIL reset_no_done: %0d dones after reset, want 0", done_count - dc0);
    end
    drive_query('{16'h3C00, 16'h4000, 16'h3800, 16'hBC00}, 0);
    c0 = best_class; s0 = best_score;
    drive_query('{16'h3C00, 16'h4000, 16'h3800, 16'hBC00}, 3);
    n_checks++;
    if (best_class !== c0 || best_score !== s0 || best_class !== 2'd1) begin
      n_fail++;
      $display("FAIL gaps: class=%0d score=%h, want %0d %h (class 1)", best_class, best_score, c0, s0);
    end
  endtask

  task automatic test_random;
    arr4_t s;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NC; i++) s[i] = 16'($urandom_range(0, 16'hFFFF));
      drive_query(s, k % 2);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ties_zeros;
    test_nan;
    test_inf;
    test_restart_overrun;
    test_reset_mid_and_gaps;
    test_random;
    repeat (3) @(posedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected results never reported, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
